// File: rtl/sram_bw_pipe.sv
// sram_bw_pipe: parametrised single-port synchronous SRAM with per-byte write
// enables, a 1- or 2-cycle read pipeline with a valid strobe, and a clear
// sequencer that zeroes the array after reset or on clr_req.
//
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per byte
// lane and flag mismatches on read return via perr. Without it perr is 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   req       in   request valid (accepted when ready=1)
//   we        in   1=write, 0=read
//   be        in   byte enables for writes, one bit per 8-bit lane
//   addr      in   word address
//   din       in   write data
//   clr_req   in   pulse to start a full-array clear (ignored while clearing)
//   ready     out  high in RUN state
//   dout      out  read data, held until the next read return
//   dout_vld  out  one-cycle strobe per accepted read, RD_LAT edges after acceptance
//   perr      out  parity error on the returned word, only with dout_vld
//
// state | meaning
// CLEAR | zeroing one word per cycle, ptr 0..DEPTH-1, requests ignored
// RUN   | normal operation, ready=1
module sram_bw_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic                clr_req,
    output logic                ready,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_vld,
    output logic                perr
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                acc;
    logic                in_range;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // stage a: accepted read address; stage b: array data captured
    logic                a_vld, a_oob;
    logic [ADDR_W-1:0]   a_addr;
    logic                b_vld, b_perr;
    logic [DATA_W-1:0]   b_data;
    logic                rd_perr;

    assign ready    = (state_q == RUN);
    assign acc      = req & ready;
    assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (acc && we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [0:DEPTH-1];

    // All-zero lanes have even parity 0, so clearing both arrays stays consistent.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            par_mem[ptr_q] <= '0;
        end else if (acc && we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) par_mem[addr][i] <= ^din[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rd_perr = rd_perr | (par_mem[a_addr][i] ^ (^mem[a_addr][8*i +: 8]));
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    // Array is sampled one edge after acceptance so a write issued the cycle
    // after a read still returns the old word, and a clear starting alongside
    // a read cannot reach the word before it is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld  <= 1'b0;
            a_oob  <= 1'b0;
            a_addr <= '0;
            b_vld  <= 1'b0;
            b_perr <= 1'b0;
            b_data <= '0;
        end else begin
            a_vld <= acc & ~we;
            if (acc && !we) begin
                a_addr <= addr;
                a_oob  <= ~in_range;
            end
            b_vld <= a_vld;
            if (a_vld) begin
                b_data <= a_oob ? '0 : mem[a_addr];
                b_perr <= a_oob ? 1'b0 : rd_perr;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              c_vld, c_perr;
            logic [DATA_W-1:0] c_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_vld  <= 1'b0;
                    c_perr <= 1'b0;
                    c_data <= '0;
                end else begin
                    c_vld <= b_vld;
                    if (b_vld) begin
                        c_data <= b_data;
                        c_perr <= b_perr;
                    end
                end
            end

            assign dout     = c_data;
            assign dout_vld = c_vld;
            assign perr     = c_perr & c_vld;
        end else begin : g_lat1
            assign dout     = b_data;
            assign dout_vld = b_vld;
            assign perr     = b_perr & b_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sram_bw_pipe.sv
// Directed bench for sram_bw_pipe: two instances (RD_LAT=1 and RD_LAT=2)
// share one stimulus stream, 32-bit data, 16 words behind a 5-bit address.
module tb_sram_bw_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [3:0]        be = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] din = '0;
    logic              clr_req = 1'b0;

    logic              ready1, vld1, perr1;
    logic [DATA_W-1:0] dout1;
    logic              ready2, vld2, perr2;
    logic [DATA_W-1:0] dout2;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    sram_bw_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .clr_req(clr_req), .ready(ready1), .dout(dout1), .dout_vld(vld1), .perr(perr1));

    sram_bw_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .clr_req(clr_req), .ready(ready2), .dout(dout2), .dout_vld(vld2), .perr(perr2));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] b, input logic [DATA_W-1:0] d);
        req = 1'b1; we = 1'b1; be = b; addr = a; din = d;
        step();
        req = 1'b0; we = 1'b0;
        chk_eq("wr_no_vld", {vld1, vld2}, 2'b00);
    endtask

    task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        req = 1'b1; we = 1'b0; addr = a;
        step();
        req = 1'b0;
        chk_eq({tag, "_vld_early"}, {vld1, vld2}, 2'b00);
        step();
        chk_eq({tag, "_l1"}, {vld1, perr1, dout1}, {2'b10, exp});
        chk_eq({tag, "_l2_wait"}, vld2, 1'b0);
        step();
        chk_eq({tag, "_l1_done"}, vld1, 1'b0);
        chk_eq({tag, "_l2"}, {vld2, perr2, dout2}, {2'b10, exp});
    endtask

    task automatic count_clear(input string tag);
        n = 0;
        while (!ready1 && n < 40) begin
            step();
            n++;
        end
        chk_eq({tag, "_len"}, n, 16);
        chk_eq({tag, "_rdy2"}, ready2, 1'b1);
    endtask

    initial begin
        #2;
        chk_eq("rst_out1", {ready1, vld1, perr1, dout1}, '0);
        chk_eq("rst_out2", {ready2, vld2, perr2, dout2}, '0);
        step();
        step();
        rst = 1'b0;
        count_clear("clr_init");

        rd_check("init_rd0", 0, 32'h0);
        rd_check("init_rd9", 9, 32'h0);

        // byte-lane merge
        wr(3, 4'b1111, 32'h1122_3344);
        wr(3, 4'b0101, 32'hAABB_CCDD);
        rd_check("be_merge", 3, 32'h11BB_33DD);

        // read at N, write same address at N+1 returns old data
        req = 1'b1; we = 1'b0; addr = 3;
        step();
        we = 1'b1; be = 4'hF; din = 32'hFFFF_FFFF;
        step();
        req = 1'b0; we = 1'b0;
        chk_eq("rd_old_l1", {vld1, dout1}, {1'b1, 32'h11BB_33DD});
        step();
        chk_eq("rd_old_l2", {vld2, dout2}, {1'b1, 32'h11BB_33DD});
        rd_check("rd_new", 3, 32'hFFFF_FFFF);

        wr(3, 4'b0000, 32'h0);
        rd_check("be_zero", 3, 32'hFFFF_FFFF);

        // write then read next cycle, then back-to-back reads
        wr(1, 4'hF, 32'h0000_00AA);
        rd_check("wr_rd", 1, 32'h0000_00AA);
        wr(2, 4'hF, 32'h1234_5678);
        req = 1'b1; we = 1'b0; addr = 1;
        step();
        addr = 2;
        step();
        chk_eq("b2b_1_l1", {vld1, dout1}, {1'b1, 32'h0000_00AA});
        addr = 1;
        step();
        req = 1'b0;
        chk_eq("b2b_2_l1", {vld1, dout1}, {1'b1, 32'h1234_5678});
        chk_eq("b2b_1_l2", {vld2, dout2}, {1'b1, 32'h0000_00AA});
        step();
        chk_eq("b2b_3_l1", {vld1, dout1}, {1'b1, 32'h0000_00AA});
        chk_eq("b2b_2_l2", {vld2, dout2}, {1'b1, 32'h1234_5678});
        step();
        chk_eq("b2b_end_l1", vld1, 1'b0);
        chk_eq("b2b_3_l2", {vld2, dout2}, {1'b1, 32'h0000_00AA});
        step();
        chk_eq("b2b_end_l2", vld2, 1'b0);

        // out-of-range addresses
        wr(4, 4'hF, 32'h0000_0044);
        wr(20, 4'hF, 32'h5555_5555);
        rd_check("oob_rd", 20, 32'h0);
        rd_check("oob_noalias", 4, 32'h0000_0044);

        // fill, then clear with a read in the same cycle
        for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), 4'hF, 32'hA000_0000 | i);
        req = 1'b1; we = 1'b0; addr = 5; clr_req = 1'b1;
        step();
        req = 1'b0; clr_req = 1'b0;
        chk_eq("clr_rdy_low", ready1, 1'b0);
        n = 0;
        while (!ready1 && n < 40) begin
            step();
            n++;
            if (n == 1) chk_eq("clr_rd_l1", {vld1, dout1}, {1'b1, 32'hA000_0005});
            if (n == 2) chk_eq("clr_rd_l2", {vld2, dout2}, {1'b1, 32'hA000_0005});
            if (n == 3) begin
                req = 1'b1; we = 1'b1; be = 4'hF; addr = 3; din = 32'hDEAD_BEEF;
            end
            if (n == 5) clr_req = 1'b1;
            if (n == 6) clr_req = 1'b0;
        end
        req = 1'b0; we = 1'b0;
        chk_eq("clr_len", n, 16);
        for (int i = 0; i < DEPTH; i++) rd_check("post_clr", ADDR_W'(i), 32'h0);

        // reset with a read in flight, then again mid-clear
        wr(1, 4'hF, 32'h0000_00AA);
        rd_check("pre_rst", 1, 32'h0000_00AA);
        req = 1'b1; we = 1'b0; addr = 1;
        step();
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk_eq("rst_flush1", {ready1, vld1, dout1}, '0);
        chk_eq("rst_flush2", {ready2, vld2, dout2}, '0);
        step();
        step();
        chk_eq("rst_hold", {vld1, vld2}, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_eq("mid_clr_rdy", ready1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_clear("clr_restart");
        chk_eq("rst_no_vld", {vld1, vld2}, 2'b00);
        rd_check("post_rst", 1, 32'h0);

`ifdef SRAM_PARITY_EN
        // lane parities of 01020304: lane0 1, lane1 0, lane2 1, lane3 1 -> 4'b1101
        wr(7, 4'hF, 32'h0102_0304);
        force u_lat1.par_mem[7] = 4'b1100;
        force u_lat2.par_mem[7] = 4'b1100;
        req = 1'b1; we = 1'b0; addr = 7;
        step();
        req = 1'b0;
        step();
        chk_eq("perr_l1", {vld1, perr1, dout1}, {2'b11, 32'h0102_0304});
        step();
        chk_eq("perr_l1_off", perr1, 1'b0);
        chk_eq("perr_l2", {vld2, perr2, dout2}, {2'b11, 32'h0102_0304});
        release u_lat1.par_mem[7];
        release u_lat2.par_mem[7];
        wr(7, 4'hF, 32'h0102_0304);
        rd_check("perr_fixed", 7, 32'h0102_0304);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
